// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection (optional ID_EX_PERF_CNT_EN counters)
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [4:0]        id_rs1_i,
    input  logic [4:0]        id_rs2_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [DATA_W-1:0] id_rs1_data_i,
    input  logic [DATA_W-1:0] id_rs2_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              flush_i,
    input  logic              freeze_i,
    output logic              pc_write_o,
    output logic              if_id_write_o,
    output logic              hazard_o,
    output logic              ex_valid_o,
    output logic [4:0]        ex_rs1_o,
    output logic [4:0]        ex_rs2_o,
    output logic [4:0]        ex_rd_o,
    output logic [DATA_W-1:0] ex_rs1_data_o,
    output logic [DATA_W-1:0] ex_rs2_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc_o,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_flush_cnt_o,
`endif
    output logic [CTRL_W-1:0] ex_ctrl_o
);

    // MemRead bit of the control bundle marks a load in EX
    localparam int MEM_READ_BIT = 5;

    logic ex_is_load;
    logic rs1_match;
    logic rs2_match;
    logic load_use;

    // Load-use detection: a valid load in EX whose rd is read by the ID instruction
    always_comb begin
        ex_is_load = ex_valid_o && ex_ctrl_o[MEM_READ_BIT] && (ex_rd_o != 5'd0);
        rs1_match  = id_uses_rs1_i && (id_rs1_i == ex_rd_o);
        rs2_match  = id_uses_rs2_i && (id_rs2_i == ex_rd_o);
        load_use   = ex_is_load && id_valid_i && (rs1_match || rs2_match);
    end

    // A flushed ID instruction is discarded anyway, so it must not block the redirect
    always_comb begin
        hazard_o      = load_use && !flush_i;
        pc_write_o    = !(hazard_o || freeze_i);
        if_id_write_o = !(hazard_o || freeze_i);
    end

    // Pipeline register: reset > freeze (hold) > flush/hazard (bubble) > load from ID
    always_ff @(posedge clk_i) begin
        if (rst_i || (!freeze_i && (flush_i || hazard_o))) begin
            ex_valid_o    <= 1'b0;
            ex_rs1_o      <= '0;
            ex_rs2_o      <= '0;
            ex_rd_o       <= '0;
            ex_rs1_data_o <= '0;
            ex_rs2_data_o <= '0;
            ex_imm_o      <= '0;
            ex_pc_o       <= '0;
            ex_ctrl_o     <= '0;
        end else if (!freeze_i) begin
            ex_valid_o    <= id_valid_i;
            ex_rs1_o      <= id_rs1_i;
            ex_rs2_o      <= id_rs2_i;
            ex_rd_o       <= id_rd_i;
            ex_rs1_data_o <= id_rs1_data_i;
            ex_rs2_data_o <= id_rs2_data_i;
            ex_imm_o      <= id_imm_i;
            ex_pc_o       <= id_pc_i;
            ex_ctrl_o     <= id_valid_i ? id_ctrl_i : '0;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Saturating counts of bubbles actually loaded; frozen edges load nothing
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else if (!freeze_i) begin
            if (flush_i && (perf_flush_cnt_o != 32'hFFFF_FFFF)) begin
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
            end
            if (hazard_o && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard testbench for id_ex_stage
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [7:0]  ctrl;
    } ex_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_uses_rs1, id_uses_rs2;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [7:0]  id_ctrl;
    logic        flush, freeze;
    logic        pc_write, if_id_write, hazard;
    logic        ex_valid;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
    logic [7:0]  ex_ctrl;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    ex_t exp_q[$];
    ex_t last;

    id_ex_stage dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
        .id_imm_i(id_imm), .id_pc_i(id_pc), .id_ctrl_i(id_ctrl),
        .flush_i(flush), .freeze_i(freeze),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write), .hazard_o(hazard),
        .ex_valid_o(ex_valid), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
        .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data),
        .ex_imm_o(ex_imm), .ex_pc_o(ex_pc),
`ifdef ID_EX_PERF_CNT_EN
        .perf_stall_cnt_o(perf_stall_cnt), .perf_flush_cnt_o(perf_flush_cnt),
`endif
        .ex_ctrl_o(ex_ctrl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2,
                          input logic [7:0] ctrl, input logic [31:0] pc);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_ctrl     = ctrl;
        id_pc       = pc;
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = pc ^ 32'h0000_5A5A;
        id_imm      = pc + 32'h10;
    endtask

    // What EX should hold one edge after a normal load of the current ID fields
    function automatic ex_t from_id();
        ex_t e;
        e.v    = id_valid;
        e.rs1  = id_rs1;
        e.rs2  = id_rs2;
        e.rd   = id_rd;
        e.d1   = id_rs1_data;
        e.d2   = id_rs2_data;
        e.imm  = id_imm;
        e.pc   = id_pc;
        e.ctrl = id_valid ? id_ctrl : 8'h00;
        return e;
    endfunction

    task automatic step(input string tag, input logic chk_comb, input logic exp_hz,
                        input logic exp_pw, input ex_t e);
        ex_t got;
        #1;
        if (chk_comb) begin
            chk({tag, ".hazard"}, 64'(hazard), 64'(exp_hz));
            chk({tag, ".pc_write"}, 64'(pc_write), 64'(exp_pw));
            chk({tag, ".if_id_write"}, 64'(if_id_write), 64'(exp_pw));
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 64'd0, 64'd1);
        end else begin
            got = exp_q.pop_front();
            chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(got.v));
            chk({tag, ".ex_rs1"}, 64'(ex_rs1), 64'(got.rs1));
            chk({tag, ".ex_rs2"}, 64'(ex_rs2), 64'(got.rs2));
            chk({tag, ".ex_rd"}, 64'(ex_rd), 64'(got.rd));
            chk({tag, ".ex_ctrl"}, 64'(ex_ctrl), 64'(got.ctrl));
            chk({tag, ".ex_rs1_data"}, 64'(ex_rs1_data), 64'(got.d1));
            chk({tag, ".ex_rs2_data"}, 64'(ex_rs2_data), 64'(got.d2));
            chk({tag, ".ex_imm"}, 64'(ex_imm), 64'(got.imm));
            chk({tag, ".ex_pc"}, 64'(ex_pc), 64'(got.pc));
            last = got;
        end
    endtask

    task automatic perf(input string tag, input int stall_n, input int flush_n);
`ifdef ID_EX_PERF_CNT_EN
        chk({tag, ".stall_cnt"}, 64'(perf_stall_cnt), 64'(stall_n));
        chk({tag, ".flush_cnt"}, 64'(perf_flush_cnt), 64'(flush_n));
`else
        if (stall_n < 0 || flush_n < 0) $display("note %s", tag);
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'h00, 32'h0);
        step("reset", 1'b0, 1'b0, 1'b1, '0);
        perf("reset", 0, 0);
        rst = 1'b0;

        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 8'h80, 32'h100);
        step("add_pass", 1'b1, 1'b0, 1'b1, from_id());
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'hE2, 32'h104);
        step("lw_x5", 1'b1, 1'b0, 1'b1, from_id());
        set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 8'h80, 32'h108);
        step("lu_stall", 1'b1, 1'b1, 1'b0, '0);
        step("lu_issue", 1'b1, 1'b0, 1'b1, from_id());
        perf("lu_issue", 1, 0);

        set_id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 8'hE2, 32'h10C);
        step("lw_x0", 1'b1, 1'b0, 1'b1, from_id());
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, 8'h80, 32'h110);
        step("x0_nostall", 1'b1, 1'b0, 1'b1, from_id());
        set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'hE2, 32'h114);
        step("lw_x5_b", 1'b1, 1'b0, 1'b1, from_id());
        set_id(1'b1, 5'd9, 5'd5, 5'd10, 1'b1, 1'b0, 8'h80, 32'h118);
        step("rs2_unused", 1'b1, 1'b0, 1'b1, from_id());

        set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'hE2, 32'h11C);
        step("lw_x5_c", 1'b1, 1'b0, 1'b1, from_id());
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 8'h80, 32'h120);
        flush = 1'b1;
        step("flush_hz", 1'b1, 1'b0, 1'b1, '0);
        flush = 1'b0;
        perf("flush_hz", 1, 1);

        set_id(1'b0, 5'd3, 5'd4, 5'd7, 1'b1, 1'b1, 8'h80, 32'h124);
        step("invalid_id", 1'b1, 1'b0, 1'b1, from_id());

        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 8'hE2, 32'h128);
        step("lw_x5_d", 1'b1, 1'b0, 1'b1, from_id());
        set_id(1'b1, 5'd5, 5'd0, 5'd11, 1'b1, 1'b0, 8'h80, 32'h12C);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) step("freeze_hz", 1'b1, 1'b1, 1'b0, last);
        freeze = 1'b0;
        perf("freeze_hz", 1, 1);
        step("post_freeze_stall", 1'b1, 1'b1, 1'b0, '0);
        perf("post_freeze_stall", 2, 1);
        step("post_freeze_issue", 1'b1, 1'b0, 1'b1, from_id());

        set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 8'h80, 32'h130);
        freeze = 1'b1;
        step("freeze_plain", 1'b1, 1'b0, 1'b0, last);
        freeze = 1'b0;
        step("unfreeze_load", 1'b1, 1'b0, 1'b1, from_id());

        set_id(1'b1, 5'd2, 5'd0, 5'd5, 1'b1, 1'b0, 8'hE2, 32'h134);
        step("lw_x5_e", 1'b1, 1'b0, 1'b1, from_id());
        set_id(1'b1, 5'd5, 5'd0, 5'd13, 1'b1, 1'b0, 8'h80, 32'h138);
        rst = 1'b1;
        step("rst_mid_stall", 1'b1, 1'b1, 1'b0, '0);
        perf("rst_mid_stall", 0, 0);
        rst = 1'b0;
        step("after_rst", 1'b1, 1'b0, 1'b1, from_id());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, combined with load-use hazard detection.
- Captures decoded operands, register indices and control from ID. Presents them to EX: ex_rs1_o and ex_rs2_o feed the forwarding unit, ex_rd_o and ex_ctrl_o flow on to EX/MEM.
- Generates PC / IF-ID write-enables and inserts bubbles on load-use hazards, branch flushes and external freezes.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields.
- CTRL_W, 8, control bundle width. Bit map: [7] RegWrite, [6] MemtoReg, [5] MemRead, [4] MemWrite, [3:2] ALUOp, [1] ALUSrc, [0] Branch.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; synchronous, active-high
- id_valid_i  in  1  ID holds a real instruction
- id_rs1_i  in  5  source register 1 index
- id_rs2_i  in  5  source register 2 index
- id_rd_i  in  5  destination register index
- id_uses_rs1_i  in  1  instruction reads rs1
- id_uses_rs2_i  in  1  instruction reads rs2
- id_rs1_data_i  in  DATA_W  register-file read data 1
- id_rs2_data_i  in  DATA_W  register-file read data 2
- id_imm_i  in  DATA_W  immediate
- id_pc_i  in  DATA_W  instruction PC
- id_ctrl_i  in  CTRL_W  decoded control
- flush_i  in  1  squash the ID instruction (taken branch)
- freeze_i  in  1  external stall (memory busy); hold everything
- pc_write_o  out  1  PC register enable
- if_id_write_o  out  1  IF/ID register enable
- hazard_o  out  1  load-use hazard detected this cycle
- ex_valid_o  out  1  EX instruction valid
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  registered indices
- ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_pc_o  out  DATA_W each  registered data
- ex_ctrl_o  out  CTRL_W  registered control

Behaviour:
- Reset: all ex_* outputs 0 (bubble) at the first edge with rst_i=1. Reset has priority over every other input, including mid-stall or mid-flush.
- Hazard detection (combinational), all conditions required:
  - ex_valid_o is 1 and ex_ctrl_o[5] is 1;
  - ex_rd_o != 0;
  - id_valid_i is 1;
  - (id_uses_rs1_i and id_rs1_i==ex_rd_o) or (id_uses_rs2_i and id_rs2_i==ex_rd_o).
- hazard_o equals this condition, masked to 0 when flush_i=1.
- pc_write_o = if_id_write_o = !(hazard_o or freeze_i).
- Register update priority per edge:
  1. rst_i: load bubble.
  2. freeze_i: hold all ex_* unchanged. Hazard is not resolved during the freeze; it is re-evaluated next cycle.
  3. flush_i: load bubble.
  4. hazard_o: load bubble.
  5. Otherwise: load ID fields. ex_valid_o <= id_valid_i, and ex_ctrl_o is forced to 0 when id_valid_i=0.
- Bubble: ex_valid_o=0, ex_ctrl_o=0, ex_rd_o=0, ex_rs1_o=0, ex_rs2_o=0 (no forwarder match); data fields 0.
- Latency: one cycle from ID to EX. A load-use stall costs exactly one bubble. Cycle after the bubble: the load sits in MEM, ex_valid_o=0, hazard clears, the held instruction enters EX. No double stall for the same pair.
- Load to x0 never stalls. Instruction with uses_rs*=0 never stalls on that field.
- flush_i with hazard: flush wins, pc_write_o=1 (redirect proceeds).

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined: adds outputs perf_stall_cnt_o (32) and perf_flush_cnt_o (32).
  - Increment on each edge where a hazard bubble, or respectively a flush bubble, is loaded; frozen edges do not count.
  - Saturate at 0xFFFFFFFF; reset to 0.
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Pass-through: reset, then ID add x3,x1,x2 (ctrl 0x80, valid) -> next cycle ex_rd_o=3, ex_ctrl_o=0x80, ex_valid_o=1, hazard_o=0.
- Load-use: EX lw x5 (ctrl 0xE2), ID add x6,x5,x7 uses_rs1 -> hazard_o=1, pc_write_o=0, if_id_write_o=0. Next cycle ex_valid_o=0, ex_rd_o=0. Following cycle add in EX with ex_rs1_o=5, hazard_o=0.
- No false stall: EX lw x0; also EX lw x5 with ID rs2=5 but uses_rs2=0 -> hazard_o=0, pc_write_o=1.
- Flush during hazard: load-use condition plus flush_i=1 -> hazard_o=0, pc_write_o=1, EX gets bubble. With ID_EX_PERF_CNT_EN: perf_flush_cnt_o +1, perf_stall_cnt_o unchanged.
- Freeze: freeze_i=1 for 3 cycles with valid ID -> ex_* unchanged, write enables 0. Release -> ID loads next edge.
- Reset mid-stall: assert rst_i during hazard cycle -> all ex_* 0 next edge, counters 0.
